multicycle_control_fsm: RTL and testbench
=========================================

// Module: multicycle_control_fsm
// PURPOSE
// Main control state machine of the multi-cycle CPU. Sequences each instruction through
// fetch/decode/execute/memory/writeback and drives every datapath enable and mux select,
// including the 2-bit ALU operand-B select consumed by the 4:1 32-bit operand mux.
// Sits upstream of the datapath; consumes IR opcode/funct, the ALU zero flag and a memory ready handshake.
// PARAMETERS
// CNT_W  32  width of retired-instruction counter
// PORTS
// clk           in   1      rising-edge clock
// rst_n         in   1      asynchronous, active-low reset
// opcode        in   6      IR[31:26]
// funct         in   6      IR[5:0]
// alu_zero      in   1      ALU zero flag, valid in BRANCH state
// mem_ready     in   1      memory completes access this cycle
// mem_req       out  1      memory access request
// mem_we        out  1      memory write (with mem_req)
// iord          out  1      0=PC addresses memory, 1=ALUOut
// ir_we         out  1      IR load enable
// pc_we         out  1      PC load enable
// pc_src        out  2      00=ALU, 01=ALUOut, 10=jump target, 11=rs (JR)
// reg_we        out  1      register-file write enable
// reg_dst       out  2      00=rt, 01=rd, 10=$31
// wb_sel        out  2      00=ALUOut, 01=MDR, 10=PC (JAL)
// alu_srca      out  1      0=PC, 1=regA
// alu_srcb      out  2      bit0->mux address0, bit1->mux address1: 00=regB,10=4,01=signext imm,11=imm<<2
// alu_op        out  3      000=ADD,001=SUB,010=XOR,011=SLT
// illegal       out  1      one-cycle pulse on unsupported opcode/funct
// instr_count   out  CNT_W  retired instructions, wraps
// BEHAVIOUR
// - States: RESET, FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, EXEC_R, WB_R, EXEC_I, WB_I, BRANCH, JUMP, JR.
// - rst_n low (any time, mid-instruction included): state=RESET, instr_count=0; RESET decodes all outputs 0.
//   First edge after release -> FETCH. No enable asserts in RESET.
// - Outputs are combinational decode of state; exceptions below are Mealy on mem_ready/alu_zero.
// - FETCH: mem_req=1,iord=0,alu_srca=0,alu_srcb=10,alu_op=ADD,pc_src=00. ir_we=pc_we=mem_ready. Hold until mem_ready.
// - DECODE: alu_srca=0, alu_srcb=11, alu_op=ADD (branch target). Dispatch:
//   LW 0x23/SW 0x2B->MEM_ADDR; R 0x00: funct 0x20/0x22/0x2A->EXEC_R, 0x08->JR; ADDI 0x08/XORI 0x0E->EXEC_I;
//   BNE 0x05/BEQ 0x04->BRANCH; J 0x02/JAL 0x03->JUMP; else illegal=1, ->FETCH (no retire count).
// - MEM_ADDR: srca=1, srcb=01, ADD; ->MEM_READ (LW) or MEM_WRITE (SW).
// - MEM_READ: mem_req=1,iord=1; wait mem_ready, then ->MEM_WB. MEM_WB: reg_we=1,reg_dst=00,wb_sel=01.
// - MEM_WRITE: mem_req=1,mem_we=1,iord=1; wait mem_ready -> FETCH.
// - EXEC_R: srca=1,srcb=00, alu_op from funct. WB_R: reg_we, reg_dst=01, wb_sel=00.
// - EXEC_I: srca=1,srcb=01, ADD or XOR. WB_I: reg_we, reg_dst=00, wb_sel=00.
// - BRANCH: srca=1,srcb=00,SUB,pc_src=01; pc_we = BNE ? ~alu_zero : alu_zero.
// - JUMP: pc_we=1,pc_src=10; JAL also reg_we=1,reg_dst=10,wb_sel=10 (PC already +4).
// - JR: pc_we=1, pc_src=11.
// - Terminal states (MEM_WB, MEM_WRITE on ready, WB_R, WB_I, BRANCH, JUMP, JR) go to FETCH and increment instr_count;
//   count wraps 2^CNT_W-1 -> 0.
// - Latency with zero-wait memory: R/I 4, LW 5, SW 4, branch/J/JAL/JR 3 cycles. Each mem_ready=0 cycle adds one.
// - DECODE latches nothing; opcode/funct must stay stable from IR until return to FETCH (IR only written in FETCH).
// STRUCTURE
// - Shared package cpu_ctrl_pkg: state enum, opcode/funct constants, ALU_OP_*, ALUSRCB_* (REGB=00,FOUR=10,IMM=01,IMM_SH2=11),
//   PC_SRC_*, REG_DST_*, WB_SEL_* encodings; datapath and this FSM both use it.
// - One sub-module natural: ctrl_decode (combinational opcode/funct -> dispatch state, alu_op, illegal).
// - State register and counter: single always block on posedge clk / negedge rst_n.
// TESTING
// - Reset mid-MEM_READ (rst_n low 1 cycle) -> all outputs 0, instr_count=0, FETCH 1 cycle after release.
// - ADD (op 0x00, funct 0x20), mem_ready=1 -> states FETCH,DECODE,EXEC_R,WB_R; reg_we=1 reg_dst=01 in cycle 4; count 1.
// - LW with mem_ready low 3 cycles in MEM_READ -> 8 cycles total, mem_req held, reg_we only in MEM_WB with wb_sel=01.
// - BNE alu_zero=0 -> pc_we=1 pc_src=01; BEQ alu_zero=0 -> pc_we=0; both return FETCH, count +1.
// - JAL -> JUMP: pc_we=1,pc_src=10,reg_we=1,reg_dst=10,wb_sel=10; DECODE alu_srcb=11, FETCH alu_srcb=10.
// - opcode 0x3F -> illegal pulse in DECODE, back to FETCH, count unchanged; count preset near 2^CNT_W-1 wraps to 0.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle CPU control path and datapath:
// FSM states, opcode/funct values, ALU op and all mux-select codes.
package cpu_ctrl_pkg;

   typedef enum logic [3:0] {
      ST_RESET,
      ST_FETCH,
      ST_DECODE,
      ST_MEM_ADDR,
      ST_MEM_READ,
      ST_MEM_WB,
      ST_MEM_WRITE,
      ST_EXEC_R,
      ST_WB_R,
      ST_EXEC_I,
      ST_WB_I,
      ST_BRANCH,
      ST_JUMP,
      ST_JR
   } state_e;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_JR    = 6'h08;
   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_SLT   = 6'h2A;

   localparam logic [2:0] ALU_OP_ADD = 3'b000;
   localparam logic [2:0] ALU_OP_SUB = 3'b001;
   localparam logic [2:0] ALU_OP_XOR = 3'b010;
   localparam logic [2:0] ALU_OP_SLT = 3'b011;

   // bit0 drives operand mux address0, bit1 drives address1
   localparam logic [1:0] ALUSRCB_REGB    = 2'b00;
   localparam logic [1:0] ALUSRCB_FOUR    = 2'b10;
   localparam logic [1:0] ALUSRCB_IMM     = 2'b01;
   localparam logic [1:0] ALUSRCB_IMM_SH2 = 2'b11;

   localparam logic [1:0] PC_SRC_ALU    = 2'b00;
   localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
   localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
   localparam logic [1:0] PC_SRC_RS     = 2'b11;

   localparam logic [1:0] REG_DST_RT = 2'b00;
   localparam logic [1:0] REG_DST_RD = 2'b01;
   localparam logic [1:0] REG_DST_RA = 2'b10;

   localparam logic [1:0] WB_SEL_ALUOUT = 2'b00;
   localparam logic [1:0] WB_SEL_MDR    = 2'b01;
   localparam logic [1:0] WB_SEL_PC     = 2'b10;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decode: opcode/funct -> dispatch state,
// execute-phase ALU operation and illegal-instruction flag.
module ctrl_decode
   import cpu_ctrl_pkg::*;
(
   input  logic [5:0] opcode_i,
   input  logic [5:0] funct_i,
   output state_e     dispatch_o,
   output logic [2:0] alu_op_o,
   output logic       illegal_o
);

   always_comb begin
      dispatch_o = ST_FETCH;
      alu_op_o   = ALU_OP_ADD;
      illegal_o  = 1'b0;
      case (opcode_i)
         OP_LW, OP_SW: dispatch_o = ST_MEM_ADDR;
         OP_RTYPE: begin
            case (funct_i)
               FN_ADD: dispatch_o = ST_EXEC_R;
               FN_SUB: begin
                  dispatch_o = ST_EXEC_R;
                  alu_op_o   = ALU_OP_SUB;
               end
               FN_SLT: begin
                  dispatch_o = ST_EXEC_R;
                  alu_op_o   = ALU_OP_SLT;
               end
               FN_JR:   dispatch_o = ST_JR;
               default: illegal_o  = 1'b1;
            endcase
         end
         OP_ADDI: dispatch_o = ST_EXEC_I;
         OP_XORI: begin
            dispatch_o = ST_EXEC_I;
            alu_op_o   = ALU_OP_XOR;
         end
         OP_BEQ, OP_BNE: dispatch_o = ST_BRANCH;
         OP_J, OP_JAL:   dispatch_o = ST_JUMP;
         default:        illegal_o  = 1'b1;
      endcase
   end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle CPU main control FSM: sequences fetch/decode/execute/memory/writeback,
// drives all datapath enables and selects, stalls on mem_ready and counts retired instructions.
module multicycle_control_fsm
   import cpu_ctrl_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [5:0]       opcode,
   input  logic [5:0]       funct,
   input  logic             alu_zero,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             mem_we,
   output logic             iord,
   output logic             ir_we,
   output logic             pc_we,
   output logic [1:0]       pc_src,
   output logic             reg_we,
   output logic [1:0]       reg_dst,
   output logic [1:0]       wb_sel,
   output logic             alu_srca,
   output logic [1:0]       alu_srcb,
   output logic [2:0]       alu_op,
   output logic             illegal,
   output logic [CNT_W-1:0] instr_count
);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             retire;

   state_e           dec_dispatch;
   logic [2:0]       dec_alu_op;
   logic             dec_illegal;

   ctrl_decode u_decode (
      .opcode_i   (opcode),
      .funct_i    (funct),
      .dispatch_o (dec_dispatch),
      .alu_op_o   (dec_alu_op),
      .illegal_o  (dec_illegal)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_RESET;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      retire   = 1'b0;
      mem_req  = 1'b0;
      mem_we   = 1'b0;
      iord     = 1'b0;
      ir_we    = 1'b0;
      pc_we    = 1'b0;
      pc_src   = PC_SRC_ALU;
      reg_we   = 1'b0;
      reg_dst  = REG_DST_RT;
      wb_sel   = WB_SEL_ALUOUT;
      alu_srca = 1'b0;
      alu_srcb = ALUSRCB_REGB;
      alu_op   = ALU_OP_ADD;
      illegal  = 1'b0;

      case (state_q)
         ST_RESET: state_d = ST_FETCH;
         ST_FETCH: begin
            mem_req  = 1'b1;
            alu_srcb = ALUSRCB_FOUR;
            ir_we    = mem_ready;
            pc_we    = mem_ready;
            if (mem_ready) state_d = ST_DECODE;
         end
         ST_DECODE: begin
            // speculative branch target: PC+4 + (imm<<2)
            alu_srcb = ALUSRCB_IMM_SH2;
            illegal  = dec_illegal;
            state_d  = dec_dispatch;
         end
         ST_MEM_ADDR: begin
            alu_srca = 1'b1;
            alu_srcb = ALUSRCB_IMM;
            state_d  = (opcode == OP_SW) ? ST_MEM_WRITE : ST_MEM_READ;
         end
         ST_MEM_READ: begin
            mem_req = 1'b1;
            iord    = 1'b1;
            if (mem_ready) state_d = ST_MEM_WB;
         end
         ST_MEM_WB: begin
            reg_we = 1'b1;
            wb_sel = WB_SEL_MDR;
            retire = 1'b1;
         end
         ST_MEM_WRITE: begin
            mem_req = 1'b1;
            mem_we  = 1'b1;
            iord    = 1'b1;
            retire  = mem_ready;
         end
         ST_EXEC_R: begin
            alu_srca = 1'b1;
            alu_op   = dec_alu_op;
            state_d  = ST_WB_R;
         end
         ST_WB_R: begin
            reg_we  = 1'b1;
            reg_dst = REG_DST_RD;
            retire  = 1'b1;
         end
         ST_EXEC_I: begin
            alu_srca = 1'b1;
            alu_srcb = ALUSRCB_IMM;
            alu_op   = dec_alu_op;
            state_d  = ST_WB_I;
         end
         ST_WB_I: begin
            reg_we = 1'b1;
            retire = 1'b1;
         end
         ST_BRANCH: begin
            alu_srca = 1'b1;
            alu_op   = ALU_OP_SUB;
            pc_src   = PC_SRC_ALUOUT;
            pc_we    = (opcode == OP_BNE) ? ~alu_zero : alu_zero;
            retire   = 1'b1;
         end
         ST_JUMP: begin
            pc_we  = 1'b1;
            pc_src = PC_SRC_JUMP;
            if (opcode == OP_JAL) begin
               reg_we  = 1'b1;
               reg_dst = REG_DST_RA;
               wb_sel  = WB_SEL_PC;
            end
            retire = 1'b1;
         end
         ST_JR: begin
            pc_we  = 1'b1;
            pc_src = PC_SRC_RS;
            retire = 1'b1;
         end
         default: state_d = ST_RESET;
      endcase

      if (retire) state_d = ST_FETCH;
      cnt_d = retire ? cnt_q + CNT_W'(1) : cnt_q;
   end

   assign instr_count = cnt_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench: each instruction is checked cycle by cycle against an event
// timeline derived from instruction class, fetch wait and memory wait counts.
module tb_multicycle_control_fsm;

   localparam int CW = 4;

   localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BEQ = 4, K_BNE = 5,
                  K_J = 6, K_JAL = 7, K_JR = 8, K_ILL = 9;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [5:0]    opcode = '0, funct = '0;
   logic          alu_zero = 1'b0, mem_ready = 1'b0;
   logic          mem_req, mem_we, iord, ir_we, pc_we, reg_we, alu_srca, illegal;
   logic [1:0]    pc_src, reg_dst, wb_sel, alu_srcb;
   logic [2:0]    alu_op;
   logic [CW-1:0] instr_count;

   logic [18:0]   all_out;
   logic [5:0]    ev;

   int n_chk = 0;
   int n_err = 0;
   int exp_cnt = 0;

   multicycle_control_fsm #(.CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
      .alu_zero(alu_zero), .mem_ready(mem_ready),
      .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_we(ir_we),
      .pc_we(pc_we), .pc_src(pc_src), .reg_we(reg_we), .reg_dst(reg_dst),
      .wb_sel(wb_sel), .alu_srca(alu_srca), .alu_srcb(alu_srcb),
      .alu_op(alu_op), .illegal(illegal), .instr_count(instr_count)
   );

   always #5 clk = ~clk;

   assign all_out = {mem_req, mem_we, iord, ir_we, pc_we, pc_src, reg_we,
                     reg_dst, wb_sel, alu_srca, alu_srcb, alu_op, illegal};
   assign ev      = {mem_req, mem_we, ir_we, pc_we, reg_we, illegal};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
      case (op)
         6'h23: return K_LW;
         6'h2B: return K_SW;
         6'h00: begin
            if (fn == 6'h20 || fn == 6'h22 || fn == 6'h2A) return K_R;
            if (fn == 6'h08) return K_JR;
            return K_ILL;
         end
         6'h08, 6'h0E: return K_I;
         6'h04: return K_BEQ;
         6'h05: return K_BNE;
         6'h02: return K_J;
         6'h03: return K_JAL;
         default: return K_ILL;
      endcase
   endfunction

   function automatic logic [2:0] exec_op(input logic [5:0] op, input logic [5:0] fn);
      if (op == 6'h0E) return 3'b010;
      if (op == 6'h00 && fn == 6'h22) return 3'b001;
      if (op == 6'h00 && fn == 6'h2A) return 3'b011;
      return 3'b000;
   endfunction

   // Called at posedge+1 with the DUT in FETCH; returns at posedge+1 of the next FETCH.
   task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                            input int fw, input int mw, input logic zero);
      int k, len, d0, last;
      bit is_mem, in_fetch, in_data, jmp;
      logic e_mreq, e_mwe, e_irwe, e_pcwe, e_regwe, e_ill;
      k      = classify(op, fn);
      is_mem = (k == K_LW || k == K_SW);
      jmp    = (k == K_J || k == K_JAL || k == K_JR);
      case (k)
         K_R, K_I, K_SW: len = 4;
         K_LW:           len = 5;
         K_ILL:          len = 2;
         default:        len = 3;
      endcase
      len    = len + fw + (is_mem ? mw : 0);
      d0     = fw + 3;
      last   = len - 1;
      opcode   = op;
      funct    = fn;
      alu_zero = zero;
      for (int c = 0; c < len; c++) begin
         in_fetch = (c <= fw);
         in_data  = is_mem && c >= d0 && c <= d0 + mw;
         if (in_fetch)     mem_ready = (c == fw);
         else if (in_data) mem_ready = (c == d0 + mw);
         else              mem_ready = 1'($urandom_range(0, 1));
         e_mreq  = in_fetch || in_data;
         e_mwe   = in_data && k == K_SW;
         e_irwe  = (c == fw);
         e_pcwe  = (c == fw) || (c == last && k != K_ILL && (jmp ||
                   (k == K_BEQ && zero) || (k == K_BNE && !zero)));
         e_regwe = (c == last) && (k == K_R || k == K_I || k == K_LW || k == K_JAL);
         e_ill   = (k == K_ILL) && (c == fw + 1);
         @(negedge clk);
         check("events", 32'(ev), 32'({e_mreq, e_mwe, e_irwe, e_pcwe, e_regwe, e_ill}));
         if (in_fetch)
            check("fetch_sel", 32'({iord, alu_srca, alu_srcb, alu_op, pc_src}),
                  32'({1'b0, 1'b0, 2'b10, 3'b000, 2'b00}));
         if (in_data) check("data_iord", 32'(iord), 32'd1);
         if (c == fw + 1)
            check("decode_sel", 32'({alu_srca, alu_srcb, alu_op}), 32'({1'b0, 2'b11, 3'b000}));
         if (c == fw + 2 && (k == K_R || k == K_I))
            check("exec_sel", 32'({alu_srca, alu_srcb, alu_op}),
                  32'({1'b1, (k == K_R) ? 2'b00 : 2'b01, exec_op(op, fn)}));
         if (c == fw + 2 && is_mem)
            check("addr_sel", 32'({alu_srca, alu_srcb, alu_op}), 32'({1'b1, 2'b01, 3'b000}));
         if (c == last && (k == K_BEQ || k == K_BNE))
            check("branch_sel", 32'({alu_srca, alu_srcb, alu_op, pc_src}),
                  32'({1'b1, 2'b00, 3'b001, 2'b01}));
         if (c == last && jmp)
            check("jump_pc_src", 32'(pc_src), (k == K_JR) ? 32'd3 : 32'd2);
         if (e_regwe)
            check("wb_route", 32'({reg_dst, wb_sel}),
                  (k == K_R)  ? 32'b0100 :
                  (k == K_I)  ? 32'b0000 :
                  (k == K_LW) ? 32'b0001 : 32'b1010);
         @(posedge clk);
         #1;
      end
      if (k != K_ILL) exp_cnt = (exp_cnt + 1) % (1 << CW);
      check("instr_count", 32'(instr_count), 32'(exp_cnt));
   endtask

   logic [5:0] op_tab [13] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h08, 6'h0E, 6'h23,
                               6'h2B, 6'h04, 6'h05, 6'h02, 6'h03, 6'h3F};
   logic [5:0] fn_tab [13] = '{6'h20, 6'h22, 6'h2A, 6'h08, 6'h11, 6'h00, 6'h05,
                               6'h3C, 6'h00, 6'h20, 6'h01, 6'h02, 6'h00};

   initial begin
      int sel;
      logic [5:0] rop, rfn;

      // power-on reset
      repeat (2) @(posedge clk);
      #1;
      check("reset_outputs", 32'(all_out), 32'd0);
      check("reset_count", 32'(instr_count), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("release_outputs", 32'(all_out), 32'd0);
      @(posedge clk);
      #1;

      // directed instructions: op, funct, fetch wait, mem wait, alu_zero
      run_instr(6'h00, 6'h20, 0, 0, 1'b0);   // ADD
      run_instr(6'h23, 6'h00, 0, 3, 1'b0);   // LW, 3 wait cycles -> 8 total
      run_instr(6'h2B, 6'h00, 1, 2, 1'b0);   // SW
      run_instr(6'h05, 6'h00, 0, 0, 1'b0);   // BNE taken
      run_instr(6'h04, 6'h00, 0, 0, 1'b0);   // BEQ not taken
      run_instr(6'h03, 6'h00, 0, 0, 1'b0);   // JAL
      run_instr(6'h02, 6'h00, 2, 0, 1'b1);   // J
      run_instr(6'h00, 6'h08, 0, 0, 1'b0);   // JR
      run_instr(6'h08, 6'h00, 0, 0, 1'b0);   // ADDI
      run_instr(6'h0E, 6'h00, 0, 0, 1'b0);   // XORI
      run_instr(6'h00, 6'h22, 0, 0, 1'b1);   // SUB
      run_instr(6'h00, 6'h2A, 1, 0, 1'b0);   // SLT
      run_instr(6'h3F, 6'h00, 0, 0, 1'b0);   // illegal opcode
      run_instr(6'h00, 6'h3F, 0, 0, 1'b0);   // illegal funct

      // reset while a load waits in MEM_READ
      opcode = 6'h23;
      funct  = 6'h00;
      mem_ready = 1'b1;
      @(posedge clk);
      #1;
      mem_ready = 1'b0;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      check("mem_read_wait", 32'({mem_req, iord}), 32'b11);
      #1 rst_n = 1'b0;
      #1;
      check("midreset_outputs", 32'(all_out), 32'd0);
      check("midreset_count", 32'(instr_count), 32'd0);
      exp_cnt = 0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("midreset_release", 32'(all_out), 32'd0);
      @(posedge clk);
      #1;
      run_instr(6'h00, 6'h20, 0, 0, 1'b0);

      // drive the counter to its top value, then wrap
      while (exp_cnt != (1 << CW) - 1) run_instr(6'h02, 6'h00, 0, 0, 1'b0);
      run_instr(6'h02, 6'h00, 0, 0, 1'b0);
      check("count_wrapped", 32'(instr_count), 32'd0);

      // randomized instruction mix
      for (int n = 0; n < 300; n++) begin
         sel = $urandom_range(0, 13);
         if (sel == 13) begin
            rop = 6'($urandom);
            rfn = 6'($urandom);
         end else begin
            rop = op_tab[sel];
            rfn = fn_tab[sel];
         end
         run_instr(rop, rfn, $urandom_range(0, 2), $urandom_range(0, 3),
                   1'($urandom_range(0, 1)));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
